// File: rtl/wb_regbank_slave.sv
// wb_regbank_slave: Wishbone classic register bank with sticky/masked IRQ controller; define WB_REGBANK_TXCNT_EN to add the TXCNT register
module wb_regbank_slave #(
    parameter int NREGS  = 8,
    parameter int NIRQ   = 4,
    parameter bit ERR_EN = 1
) (
    input  logic                  p_clk,
    input  logic                  p_resetn,
    input  logic [NIRQ-1:0]       raise_irq,
    output logic                  irq,
    output logic [NREGS*32-1:0]   module_regs,
    output logic [NREGS-1:0]      initialized,
    input  logic [31:0]           p_wb_DAT_I,
    output logic [31:0]           p_wb_DAT_O,
    input  logic [31:0]           p_wb_ADR_I,
    output logic                  p_wb_ACK_O,
    input  logic                  p_wb_CYC_I,
    output logic                  p_wb_ERR_O,
    input  logic                  p_wb_LOCK_I,
    output logic                  p_wb_RTY_O,
    input  logic [3:0]            p_wb_SEL_I,
    input  logic                  p_wb_STB_I,
    input  logic                  p_wb_WE_I
);
    typedef enum logic {IDLE, RESP} state_t;
`ifdef WB_REGBANK_TXCNT_EN
    localparam int TX = 1;
`else
    localparam int TX = 0;
`endif
    localparam logic [29:0] I_STAT = 30'(NREGS);
    localparam logic [29:0] I_MASK = 30'(NREGS + 1);
    localparam logic [29:0] N_MAP  = 30'(NREGS + 2 + TX);

    state_t            state, state_nx;
    logic [31:0]       regs [NREGS];
    logic [NIRQ-1:0]   irq_status, irq_mask, stat_clr;
    logic [29:0]       idx;
    logic              req, valid, wr, unused;
    logic [31:0]       wmask, rdata;
`ifdef WB_REGBANK_TXCNT_EN
    localparam logic [29:0] I_TX = 30'(NREGS + 2);
    logic [31:0]       txcnt;
`endif

    assign unused     = p_wb_LOCK_I;
    assign p_wb_RTY_O = 1'b0;
    assign idx        = p_wb_ADR_I[31:2];
    assign req        = state == IDLE && p_wb_CYC_I && p_wb_STB_I;
    assign valid      = p_wb_ADR_I[1:0] == 2'b00 && idx < N_MAP;
    assign wr         = req && p_wb_WE_I && valid;
    assign wmask      = {{8{p_wb_SEL_I[3]}}, {8{p_wb_SEL_I[2]}}, {8{p_wb_SEL_I[1]}}, {8{p_wb_SEL_I[0]}}};
    assign stat_clr   = wr && idx == I_STAT ? p_wb_DAT_I[NIRQ-1:0] & wmask[NIRQ-1:0] : '0;

    for (genvar i = 0; i < NREGS; i++) begin : g_out
        assign module_regs[32*i +: 32] = regs[i];
    end

    always_comb begin
        rdata = '0;
        for (int r = 0; r < NREGS; r++)
            if (idx == 30'(r)) rdata = regs[r];
        if (idx == I_STAT) rdata = 32'(irq_status);
        if (idx == I_MASK) rdata = 32'(irq_mask);
`ifdef WB_REGBANK_TXCNT_EN
        if (idx == I_TX) rdata = txcnt;
`endif
        if (!valid) rdata = '0;
    end

    always_comb state_nx = req ? RESP : IDLE;

    always_ff @(posedge p_clk) state <= !p_resetn ? IDLE : state_nx;

    always_ff @(posedge p_clk) begin
        if (!p_resetn) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
            initialized <= '0;
            irq_status  <= '0;
            irq_mask    <= '0;
            irq         <= 1'b0;
            p_wb_DAT_O  <= '0;
            p_wb_ACK_O  <= 1'b0;
            p_wb_ERR_O  <= 1'b0;
`ifdef WB_REGBANK_TXCNT_EN
            txcnt       <= '0;
`endif
        end else begin
            p_wb_ACK_O <= req && (valid || !ERR_EN);
            p_wb_ERR_O <= req && !valid && ERR_EN;
            if (req && !p_wb_WE_I) p_wb_DAT_O <= rdata;
            // raise is OR-ed after the clear so a simultaneous request wins
            irq_status <= (irq_status & ~stat_clr) | raise_irq;
            irq        <= |(irq_status & irq_mask);
            if (wr && idx == I_MASK)
                irq_mask <= (irq_mask & ~wmask[NIRQ-1:0]) | (p_wb_DAT_I[NIRQ-1:0] & wmask[NIRQ-1:0]);
            for (int r = 0; r < NREGS; r++)
                if (wr && idx == 30'(r)) begin
                    regs[r] <= (regs[r] & ~wmask) | (p_wb_DAT_I & wmask);
                    if (|p_wb_SEL_I) initialized[r] <= 1'b1;
                end
`ifdef WB_REGBANK_TXCNT_EN
            txcnt <= wr && idx == I_TX ? '0 : txcnt + 32'(req && (valid || !ERR_EN));
`endif
        end
    end
endmodule

// File: tb/tb_wb_regbank_slave.sv
// tb_wb_regbank_slave: directed table, reset/back-to-back sequences and randomized transfers against a register-map model
module tb_wb_regbank_slave;
    localparam int NR = 8;
    localparam int NI = 4;
`ifdef WB_REGBANK_TXCNT_EN
    localparam int NMAP = NR + 3;
`else
    localparam int NMAP = NR + 2;
`endif

    logic            p_clk, p_resetn, irq, ack, err, rty, cyc, stb, we_i, lock;
    logic [NI-1:0]   raise_irq;
    logic [NR*32-1:0] module_regs;
    logic [NR-1:0]   initialized;
    logic [31:0]     dat_i, dat_o, adr_i;
    logic [3:0]      sel_i;

    wb_regbank_slave #(.NREGS(NR), .NIRQ(NI), .ERR_EN(1)) dut (
        .p_clk(p_clk), .p_resetn(p_resetn), .raise_irq(raise_irq), .irq(irq),
        .module_regs(module_regs), .initialized(initialized),
        .p_wb_DAT_I(dat_i), .p_wb_DAT_O(dat_o), .p_wb_ADR_I(adr_i),
        .p_wb_ACK_O(ack), .p_wb_CYC_I(cyc), .p_wb_ERR_O(err),
        .p_wb_LOCK_I(lock), .p_wb_RTY_O(rty), .p_wb_SEL_I(sel_i),
        .p_wb_STB_I(stb), .p_wb_WE_I(we_i)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0]   m_regs [NR];
    logic [NR-1:0] m_init;
    logic [NI-1:0] m_stat, m_mask;
    logic [31:0]   m_tx;

    typedef struct {
        logic        we;
        logic [31:0] adr, dat;
        logic [3:0]  sel, raise;
        logic        err;
        logic [31:0] rd;
        logic        irq;
        logic [7:0]  init;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_init = '0;
        m_stat = '0;
        m_mask = '0;
        m_tx   = '0;
    endtask

    function automatic logic [NR*32-1:0] pack();
        logic [NR*32-1:0] p;
        for (int i = 0; i < NR; i++) p[32*i +: 32] = m_regs[i];
        return p;
    endfunction

    task automatic model_step(input logic we, input logic [31:0] adr, dat, input logic [3:0] sel, raise,
                              output logic e_ack, output logic e_err, output logic [31:0] e_rd);
        int idx = int'(adr >> 2);
        logic ok = adr[1:0] == 2'b00 && idx < NMAP;
        logic [NI-1:0] clr = '0;
        e_ack = ok;
        e_err = !ok;
        e_rd  = '0;
        if (ok && !we) begin
            if (idx < NR) e_rd = m_regs[idx];
            else if (idx == NR) e_rd = 32'(m_stat);
            else if (idx == NR + 1) e_rd = 32'(m_mask);
            else e_rd = m_tx;
        end
        if (ok && we)
            for (int b = 0; b < 4; b++)
                if (sel[b]) begin
                    if (idx < NR) begin
                        m_regs[idx][8*b +: 8] = dat[8*b +: 8];
                        m_init[idx] = 1'b1;
                    end else if (b == 0 && idx == NR) clr = dat[NI-1:0];
                    else if (b == 0 && idx == NR + 1) m_mask = dat[NI-1:0];
                end
        m_stat = (m_stat & ~clr) | raise;
        if (ok) m_tx = (we && idx == NR + 2) ? 32'd0 : m_tx + 32'd1;
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, dat, input logic [3:0] sel, raise,
                        output logic a, output logic e, output logic [31:0] rd, output logic late, output logic ir);
        @(negedge p_clk);
        cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel; raise_irq = raise;
        @(posedge p_clk); #1;
        a = ack; e = err; rd = dat_o;
        @(negedge p_clk);
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0; raise_irq = '0;
        @(posedge p_clk); #1;
        late = ack | err;
        ir = irq;
    endtask

    task automatic run(input string tag, input logic we, input logic [31:0] adr, dat, input logic [3:0] sel, raise,
                       output logic [31:0] rd, output logic e, output logic ir);
        logic ea, ee, a, late;
        logic [31:0] erd;
        model_step(we, adr, dat, sel, raise, ea, ee, erd);
        xfer(we, adr, dat, sel, raise, a, e, rd, late, ir);
        chk({tag, " resp"}, {a, e}, {ea, ee});
        if (!we && ea) chk({tag, " rdata"}, rd, erd);
        chk({tag, " resp_len"}, late, 0);
        chk({tag, " irq"}, ir, |(m_stat & m_mask));
        chk({tag, " init"}, initialized, m_init);
        chk({tag, " regs"}, module_regs, pack());
    endtask

    initial begin
        logic [31:0] rd;
        logic e, ir;
        cyc = 0; stb = 0; we_i = 0; lock = 0; adr_i = 0; dat_i = 0; sel_i = 0; raise_irq = 0;
        p_resetn = 1'b0;
        model_reset();
        repeat (3) @(posedge p_clk);
        #1;
        chk("reset ack_err", {ack, err}, 0);
        chk("reset irq", irq, 0);
        chk("reset init", initialized, 0);
        chk("reset regs", module_regs, 0);
        chk("reset dat_o", dat_o, 0);
        chk("rty", rty, 0);
        @(negedge p_clk);
        p_resetn = 1'b1;

        tbl.push_back('{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 4'h0, 1'b0, 32'h0,        1'b0, 8'h02});
        tbl.push_back('{1'b0, 32'h04, 32'h0,        4'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 8'h02});
        tbl.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 4'h0, 1'b0, 32'h0,        1'b0, 8'h02});
        tbl.push_back('{1'b0, 32'h1C, 32'h0,        4'h0, 4'h0, 1'b0, 32'h0,        1'b0, 8'h02});
        tbl.push_back('{1'b0, 32'h20, 32'h0,        4'h0, 4'h0, 1'b0, 32'h0,        1'b0, 8'h02});
        tbl.push_back('{1'b1, 32'h00, 32'h11223344, 4'hF, 4'h0, 1'b0, 32'h0,        1'b0, 8'h03});
        tbl.push_back('{1'b1, 32'h00, 32'hAABBCCDD, 4'h5, 4'h0, 1'b0, 32'h0,        1'b0, 8'h03});
        tbl.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 4'h0, 1'b0, 32'h11BB33DD, 1'b0, 8'h03});
        tbl.push_back('{1'b0, 32'h30, 32'h0,        4'h0, 4'h0, 1'b1, 32'h0,        1'b0, 8'h03});
        tbl.push_back('{1'b0, 32'h02, 32'h0,        4'h0, 4'h0, 1'b1, 32'h0,        1'b0, 8'h03});
        tbl.push_back('{1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, 4'h0, 1'b1, 32'h0,        1'b0, 8'h03});
        tbl.push_back('{1'b1, 32'h02, 32'hFFFFFFFF, 4'hF, 4'h0, 1'b1, 32'h0,        1'b0, 8'h03});
        tbl.push_back('{1'b0, 32'h00, 32'h0,        4'h0, 4'h0, 1'b0, 32'h11BB33DD, 1'b0, 8'h03});
        tbl.push_back('{1'b0, 32'h04, 32'h0,        4'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 8'h03});
        tbl.push_back('{1'b1, 32'h24, 32'h1,        4'hF, 4'h0, 1'b0, 32'h0,        1'b0, 8'h03});
        tbl.push_back('{1'b0, 32'h20, 32'h0,        4'h0, 4'h3, 1'b0, 32'h0,        1'b1, 8'h03});
        tbl.push_back('{1'b0, 32'h20, 32'h0,        4'h0, 4'h0, 1'b0, 32'h3,        1'b1, 8'h03});
        tbl.push_back('{1'b1, 32'h20, 32'h1,        4'hF, 4'h0, 1'b0, 32'h0,        1'b0, 8'h03});
        tbl.push_back('{1'b0, 32'h20, 32'h0,        4'h0, 4'h0, 1'b0, 32'h2,        1'b0, 8'h03});
        tbl.push_back('{1'b1, 32'h20, 32'h2,        4'hF, 4'h2, 1'b0, 32'h0,        1'b0, 8'h03});
        tbl.push_back('{1'b0, 32'h20, 32'h0,        4'h0, 4'h0, 1'b0, 32'h2,        1'b0, 8'h03});
        tbl.push_back('{1'b1, 32'h1C, 32'h12345678, 4'h0, 4'h0, 1'b0, 32'h0,        1'b0, 8'h03});
        tbl.push_back('{1'b0, 32'h1C, 32'h0,        4'h0, 4'h0, 1'b0, 32'h0,        1'b0, 8'h03});
        tbl.push_back('{1'b0, 32'h24, 32'h0,        4'h0, 4'h0, 1'b0, 32'h1,        1'b0, 8'h03});

        foreach (tbl[k]) begin
            string t = $sformatf("vec%0d", k);
            run(t, tbl[k].we, tbl[k].adr, tbl[k].dat, tbl[k].sel, tbl[k].raise, rd, e, ir);
            chk({t, " err"}, e, tbl[k].err);
            if (!tbl[k].we && !tbl[k].err) chk({t, " rd"}, rd, tbl[k].rd);
            chk({t, " irq_tbl"}, ir, tbl[k].irq);
            chk({t, " init_tbl"}, initialized, tbl[k].init);
        end

        // reset lands while the read response is on the bus
        @(negedge p_clk);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = 32'h04; raise_irq = 4'h1;
        @(posedge p_clk); #1;
        chk("rst_resp ack", ack, 1);
        @(negedge p_clk);
        p_resetn = 1'b0; cyc = 1'b0; stb = 1'b0; raise_irq = '0;
        @(posedge p_clk); #1;
        chk("rst_resp ack_err", {ack, err}, 0);
        chk("rst_resp irq", irq, 0);
        chk("rst_resp init", initialized, 0);
        chk("rst_resp regs", module_regs, 0);
        chk("rst_resp dat_o", dat_o, 0);
        @(negedge p_clk);
        p_resetn = 1'b1;
        model_reset();
        run("post_rst stat", 1'b0, 32'h20, 0, 0, 0, rd, e, ir);
        run("post_rst mask", 1'b0, 32'h24, 0, 0, 0, rd, e, ir);

`ifdef WB_REGBANK_TXCNT_EN
        run("tx clr", 1'b1, 32'h28, 32'h5, 4'hF, 0, rd, e, ir);
        run("tx w0", 1'b1, 32'h00, 32'h1, 4'hF, 0, rd, e, ir);
        run("tx w1", 1'b1, 32'h04, 32'h2, 4'hF, 0, rd, e, ir);
        run("tx w2", 1'b1, 32'h08, 32'h3, 4'hF, 0, rd, e, ir);
        run("tx rd", 1'b0, 32'h28, 0, 0, 0, rd, e, ir);
        chk("txcnt value", rd, 32'h3);
`else
        run("tx absent", 1'b0, 32'h28, 0, 0, 0, rd, e, ir);
        chk("txcnt invalid err", e, 1);
`endif

        // request held through RESP is taken again only every second cycle
        @(negedge p_clk);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = 32'h00;
        for (int k = 0; k < 4; k++) begin
            @(posedge p_clk); #1;
            chk($sformatf("b2b ack%0d", k), ack, (k % 2) == 0);
        end
        @(negedge p_clk);
        cyc = 1'b0; stb = 1'b0;
        m_tx = m_tx + 32'd2;

        for (int k = 0; k < 300; k++) begin
            logic [29:0] ri;
            logic [1:0]  lo;
            logic [31:0] adr;
            ri  = 30'($urandom_range(0, NMAP + 1));
            lo  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            adr = {ri, lo};
            if ($urandom_range(0, 15) == 0) adr = $urandom;
            run($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, rd, e, ir);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_regbank_slave.md
Name: wb_regbank_slave

Overview:
- Parametrised Wishbone classic slave holding NREGS 32-bit read/write configuration registers with byte-lane write enables and per-register "written" flags.
- Adds an NIRQ-channel interrupt controller with a sticky status register (write-1-to-clear), a mask register and a combined irq output.
- Responses are registered: ACK or ERR is returned one cycle after the request is accepted.
- Sits between the SoC Wishbone interconnect and hardware modules that need software-programmed configuration and interrupt signalling.

Parameters:
- NREGS, 8, number of generic RW registers (1..64).
- NIRQ, 4, number of interrupt channels (1..32).
- ERR_EN, 1, 1 = ERR response for invalid address; 0 = ACK with read data 0 and write dropped.

Ports:
- p_clk  in  1  clock, all logic on rising edge.
- p_resetn  in  1  reset, synchronous, active-low.
- raise_irq  in  NIRQ  per-channel interrupt request, level; sampled every cycle.
- irq  out  1  OR of (irq_status & irq_mask).
- module_regs  out  NREGS*32  register contents, reg i at bits [32*i+31:32*i].
- initialized  out  NREGS  bit i set once reg i has had any byte written.
- p_wb_DAT_I  in  32  write data.
- p_wb_DAT_O  out  32  read data, registered.
- p_wb_ADR_I  in  32  byte address.
- p_wb_ACK_O  out  1  transfer acknowledge.
- p_wb_CYC_I  in  1  bus cycle.
- p_wb_ERR_O  out  1  error response.
- p_wb_LOCK_I  in  1  ignored.
- p_wb_RTY_O  out  1  tied 0.
- p_wb_SEL_I  in  4  byte lane select.
- p_wb_STB_I  in  1  strobe.
- p_wb_WE_I  in  1  write enable.

Behaviour:
- Reset (p_resetn=0 at a clock edge): module_regs=0, initialized=0, irq_status=0, irq_mask=0, irq=0, DAT_O=0, ACK=0, ERR=0, FSM=IDLE. Reset overrides any transfer in progress; no response is issued for it.
- Register map, word index = ADR_I[31:2]:
  - 0..NREGS-1: generic registers.
  - NREGS: IRQ_STATUS, bits [NIRQ-1:0].
  - NREGS+1: IRQ_MASK, bits [NIRQ-1:0].
  - Unimplemented bits read 0.
- Invalid access: index beyond the map, or ADR_I[1:0]!=0.
- FSM IDLE:
  - If CYC&STB: perform the access this edge (write update or read capture into DAT_O), then go to RESP.
  - Invalid access: no state change; if ERR_EN=1 assert ERR next cycle, otherwise ACK with DAT_O=0.
- FSM RESP: ACK or ERR high for exactly one cycle, then return to IDLE unconditionally. The request is not re-sampled in RESP, so back-to-back transfers complete every 2 cycles. ACK and ERR are never high together.
- Writes to generic registers: byte lane b is updated only if SEL_I[b]. SEL_I=0 gives ACK with no change and initialized unchanged.
- Writes to IRQ_STATUS: bits written 1 (lanes gated by SEL) are cleared.
- Writes to IRQ_MASK: byte-lane write, as for generic registers.
- Reads ignore SEL and return the full word.
- irq_status[i] is set in every cycle raise_irq[i]=1. Set beats clear on the same edge.
- irq is registered: it reflects status & mask one cycle after the update. Masking does not clear status.
- CYC=0 or STB=0: no action. LOCK is ignored; RTY stays 0.

Optional Feature:
- Macro WB_REGBANK_TXCNT_EN.
- Defined: adds a TXCNT register at index NREGS+2, a 32-bit count of completed ACK transfers (ERR excluded).
  - Wraps 0xFFFFFFFF->0.
  - Any write clears it to 0; that write itself is not counted.
  - A read returns the value before the current transfer.
  - Reset value 0.
- Undefined: index NREGS+2 is invalid and behaves as any other invalid access.

Test Plan (NREGS=8, NIRQ=4, ERR_EN=1):
- Reset, then write 0xDEADBEEF to 0x04 with SEL=0xF, then read 0x04:
  - ACK exactly one cycle after STB each time.
  - Read returns 0xDEADBEEF.
  - initialized=0x02.
  - All other registers read 0.
- Write 0x11223344 to 0x00 with SEL=0xF, then 0xAABBCCDD with SEL=0x5: reg0 reads 0x11BB33DD.
- Read 0x30 and read 0x02: ERR one cycle each, ACK stays 0, no register changes.
- irq flow:
  - Write IRQ_MASK (0x24)=0x1.
  - Pulse raise_irq=0x3 for 1 cycle: IRQ_STATUS (0x20) reads 0x3, irq=1.
  - Write 0x1 to 0x20: status reads 0x2, irq=0.
- Hold raise_irq[1]=1 while writing 0x2 to 0x20: status bit 1 stays set (set beats clear).
- Assert p_resetn=0 during RESP: ACK drops next cycle; all outputs reach reset values. With WB_REGBANK_TXCNT_EN, after 3 ACK writes, reading 0x28 returns 0x3.
